// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch front end with the IF/ID pipeline register. It issues
// instruction-memory requests over a valid/ready handshake, tracks the PC of
// every request in flight, buffers in-order responses in a small prefetch FIFO
// and presents InstrD/PCD/InstrValidD to the decode stage.
//
// Ports
//   clk, rst_n        clock (rising edge) / asynchronous active-low reset
//   StallF            freeze PC and request issue
//   StallD            hold IF/ID register and FIFO head
//   FlushD            clear IF/ID register to a bubble (wins over StallD)
//   BranchTakenE      redirect fetch to BranchTargetE (wins over StallF)
//   BranchTargetE     redirect address
//   imem_req_valid    request valid
//   imem_req_ready    memory accepts request
//   imem_addr         request address (current PC)
//   imem_rsp_valid    in-order response valid, never back-pressured
//   imem_rsp_data     fetched instruction
//   InstrD, PCD       instruction and its PC presented to decode
//   InstrValidD       InstrD is a real instruction, not a bubble
//
// Optional feature (macro FETCH_PERF_EN):
//   perf_bubble_cnt   saturating count of bubbles loaded while !StallD
//   perf_drop_cnt     saturating count of discarded (wrong-path) responses
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                DEPTH    = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               StallF,
    input  logic               StallD,
    input  logic               FlushD,
    input  logic               BranchTakenE,
    input  logic [ADDR_W-1:0]  BranchTargetE,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    output logic [INSTR_W-1:0] InstrD,
    output logic [ADDR_W-1:0]  PCD,
    output logic               InstrValidD
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        perf_bubble_cnt,
    output logic [15:0]        perf_drop_cnt
`endif
);

    localparam int              PW      = $clog2(DEPTH);
    localparam int              CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0]     DEPTH_W = (CW+1)'(DEPTH);
    localparam logic [CW-1:0]   FULL_C  = CW'(DEPTH);

    // Architectural state
    logic [ADDR_W-1:0]  pc_reg, pc_next;
    logic [CW-1:0]      outstanding_reg, outstanding_next;
    logic [CW-1:0]      drop_reg, drop_next;
    logic [CW-1:0]      count_reg, count_next;

    // Tag queue: PC of each request in flight, in issue order
    logic [ADDR_W-1:0]  tag_mem [DEPTH];
    logic [PW-1:0]      tag_wr_reg, tag_wr_next;
    logic [PW-1:0]      tag_rd_reg, tag_rd_next;

    // Prefetch FIFO of {pc, instr}
    logic [ADDR_W-1:0]  fifo_pc    [DEPTH];
    logic [INSTR_W-1:0] fifo_instr [DEPTH];
    logic [PW-1:0]      fifo_wr_reg, fifo_wr_next;
    logic [PW-1:0]      fifo_rd_reg, fifo_rd_next;

    // IF/ID register
    logic [INSTR_W-1:0] instr_d_reg, instr_d_next;
    logic [ADDR_W-1:0]  pc_d_reg, pc_d_next;
    logic               valid_d_reg, valid_d_next;

    logic [CW:0]        inflight;
    logic               accept;
    logic               rsp_drop;
    logic               push;
    logic               pop;
    logic               fifo_empty;

    // Requests in flight plus buffered entries are capped at DEPTH, which is
    // what keeps the FIFO from ever overflowing without back-pressuring memory.
    assign inflight       = {1'b0, outstanding_reg} + {1'b0, count_reg};
    assign imem_req_valid = rst_n && !StallF && !BranchTakenE && (inflight < DEPTH_W);
    assign imem_addr      = pc_reg;
    assign accept         = imem_req_valid && imem_req_ready;

    // A response is wrong-path if older drops are pending, or if it lands in
    // the redirect cycle itself (the FIFO is being cleared that cycle).
    assign rsp_drop   = imem_rsp_valid && ((drop_reg != '0) || BranchTakenE);
    assign push       = imem_rsp_valid && !rsp_drop;
    assign fifo_empty = (count_reg == '0);
    assign pop        = !FlushD && !StallD && !fifo_empty;

    always_comb begin
        pc_next          = pc_reg;
        outstanding_next = outstanding_reg + CW'(accept) - CW'(imem_rsp_valid);
        drop_next        = drop_reg;
        count_next       = count_reg + CW'(push) - CW'(pop);
        tag_wr_next      = tag_wr_reg + PW'(accept);
        tag_rd_next      = tag_rd_reg + PW'(imem_rsp_valid);
        fifo_wr_next     = fifo_wr_reg + PW'(push);
        fifo_rd_next     = fifo_rd_reg + PW'(pop);

        if (BranchTakenE) begin
            pc_next      = BranchTargetE;
            // Everything still in flight belongs to the old path.
            drop_next    = outstanding_reg - CW'(imem_rsp_valid);
            count_next   = '0;
            fifo_wr_next = '0;
            fifo_rd_next = '0;
        end else begin
            if (accept) begin
                pc_next = pc_reg + ADDR_W'(4);
            end
            if (imem_rsp_valid && (drop_reg != '0)) begin
                drop_next = drop_reg - CW'(1);
            end
        end
    end

    // IF/ID update: flush, then stall, then load head, else bubble (PCD held)
    always_comb begin
        instr_d_next = instr_d_reg;
        pc_d_next    = pc_d_reg;
        valid_d_next = valid_d_reg;
        if (FlushD) begin
            instr_d_next = '0;
            valid_d_next = 1'b0;
        end else if (StallD) begin
            instr_d_next = instr_d_reg;
        end else if (!fifo_empty) begin
            instr_d_next = fifo_instr[fifo_rd_reg];
            pc_d_next    = fifo_pc[fifo_rd_reg];
            valid_d_next = 1'b1;
        end else begin
            instr_d_next = '0;
            valid_d_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg          <= RESET_PC;
            outstanding_reg <= '0;
            drop_reg        <= '0;
            count_reg       <= '0;
            tag_wr_reg      <= '0;
            tag_rd_reg      <= '0;
            fifo_wr_reg     <= '0;
            fifo_rd_reg     <= '0;
            instr_d_reg     <= '0;
            pc_d_reg        <= '0;
            valid_d_reg     <= 1'b0;
        end else begin
            pc_reg          <= pc_next;
            outstanding_reg <= outstanding_next;
            drop_reg        <= drop_next;
            count_reg       <= count_next;
            tag_wr_reg      <= tag_wr_next;
            tag_rd_reg      <= tag_rd_next;
            fifo_wr_reg     <= fifo_wr_next;
            fifo_rd_reg     <= fifo_rd_next;
            instr_d_reg     <= instr_d_next;
            pc_d_reg        <= pc_d_next;
            valid_d_reg     <= valid_d_next;
        end
    end

    // Storage arrays carry no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (accept) begin
            tag_mem[tag_wr_reg] <= pc_reg;
        end
        if (push) begin
            fifo_pc[fifo_wr_reg]    <= tag_mem[tag_rd_reg];
            fifo_instr[fifo_wr_reg] <= imem_rsp_data;
        end
    end

    assign InstrD      = instr_d_reg;
    assign PCD         = pc_d_reg;
    assign InstrValidD = valid_d_reg;

`ifdef FETCH_PERF_EN
    logic [31:0] bubble_cnt_reg;
    logic [15:0] drop_cnt_reg;
    logic        bubble_load;

    assign bubble_load = !StallD && (FlushD || fifo_empty);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt_reg <= '0;
            drop_cnt_reg   <= '0;
        end else begin
            if (bubble_load && (bubble_cnt_reg != '1)) begin
                bubble_cnt_reg <= bubble_cnt_reg + 32'd1;
            end
            if (rsp_drop && (drop_cnt_reg != '1)) begin
                drop_cnt_reg <= drop_cnt_reg + 16'd1;
            end
        end
    end

    assign perf_bubble_cnt = bubble_cnt_reg;
    assign perf_drop_cnt   = drop_cnt_reg;
`endif

    // The issue cap must make an overflowing push impossible.
    assert property (@(posedge clk) disable iff (!rst_n) !(push && (count_reg == FULL_C)));

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//
// Directed bench for fetch_stage (RESET_PC=0x100, DEPTH=4). A behavioural
// instruction memory with adjustable latency answers requests in order.
// Stimulus pushes the hand-computed PC sequence each phase must deliver into
// a scoreboard queue; a separate negedge monitor pops and compares whenever
// IF/ID loads a real instruction, and checks holds, flushes and bubbles.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    localparam int AW    = 32;
    localparam int IW    = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          StallF = 1'b0;
    logic          StallD = 1'b0;
    logic          FlushD = 1'b0;
    logic          BranchTakenE = 1'b0;
    logic [AW-1:0] BranchTargetE = '0;
    logic          imem_req_valid;
    logic          imem_req_ready = 1'b0;
    logic [AW-1:0] imem_addr;
    logic          imem_rsp_valid = 1'b0;
    logic [IW-1:0] imem_rsp_data = '0;
    logic [IW-1:0] InstrD;
    logic [AW-1:0] PCD;
    logic          InstrValidD;
`ifdef FETCH_PERF_EN
    logic [31:0]   perf_bubble_cnt;
    logic [15:0]   perf_drop_cnt;
`endif

    fetch_stage #(
        .ADDR_W   (AW),
        .INSTR_W  (IW),
        .RESET_PC (32'h0000_0100),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .StallF         (StallF),
        .StallD         (StallD),
        .FlushD         (FlushD),
        .BranchTakenE   (BranchTakenE),
        .BranchTargetE  (BranchTargetE),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .InstrD         (InstrD),
        .PCD            (PCD),
        .InstrValidD    (InstrValidD)
`ifdef FETCH_PERF_EN
        ,
        .perf_bubble_cnt(perf_bubble_cnt),
        .perf_drop_cnt  (perf_drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cmp_count = 0;
    int err_count = 0;
    logic [31:0] exp_q[$];

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return (pc ^ 32'h5A5A_0000) + 32'h0000_1001;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_count++;
        if (act !== exp) begin
            err_count++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_range(input logic [31:0] first, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(first + 32'(4 * i));
    endtask

    // ---------------- behavioural instruction memory ----------------
    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t mq[$];
    int   edge_cnt = 0;
    int   lat = 1;

    always @(posedge clk) edge_cnt++;

    // Decide at the negedge what the memory shows at the upcoming edge, and
    // record a request that will be accepted at that edge.
    always @(negedge clk) begin
        int   ue;
        req_t r;
        ue = edge_cnt + 1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if (!rst_n) begin
            mq.delete();
        end else begin
            if (mq.size() > 0 && mq[0].due <= ue) begin
                r = mq.pop_front();
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = instr_of(r.addr);
            end
            if (imem_req_valid && imem_req_ready) begin
                r.addr = imem_addr;
                r.due  = ue + lat;
                mq.push_back(r);
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic        prev_stall = 1'b0;
    logic        prev_flush = 1'b0;
    logic        last_valid = 1'b0;
    logic [31:0] last_pc = '0;

    always @(negedge clk) begin
        logic [31:0] e;
        if (!rst_n) begin
            last_valid = 1'b0;
            prev_stall = 1'b0;
            prev_flush = 1'b0;
        end else begin
            if (prev_flush) begin
                check("flush_valid", 32'(InstrValidD), 32'd0);
                check("flush_instr", InstrD, 32'd0);
                last_valid = 1'b0;
            end else if (prev_stall) begin
                check("hold_valid", 32'(InstrValidD), 32'(last_valid));
                if (last_valid) begin
                    check("hold_pc", PCD, last_pc);
                    check("hold_instr", InstrD, instr_of(last_pc));
                end
            end else if (InstrValidD) begin
                if (exp_q.size() == 0) begin
                    cmp_count++;
                    err_count++;
                    $display("FAIL unexpected_instr: got PCD %h expected no instruction", PCD);
                    last_pc = PCD;
                end else begin
                    e = exp_q.pop_front();
                    $display("deliver PCD=%h InstrD=%h expected PC=%h", PCD, InstrD, e);
                    check("deliver_pc", PCD, e);
                    check("deliver_instr", InstrD, instr_of(e));
                    last_pc = e;
                end
                last_valid = 1'b1;
            end else begin
                check("bubble_instr", InstrD, 32'd0);
                last_valid = 1'b0;
            end
            prev_stall = StallD;
            prev_flush = FlushD;
        end
    end

    // Wait (bounded) until every expected instruction has been delivered.
    task automatic drain();
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            cmp_count++;
            err_count++;
            $display("FAIL drain_timeout: %0d instructions undelivered, expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        // Reset: request must stay low even with StallF=0 while rst_n is low
        rst_n = 1'b0;
        StallF = 1'b0;
        imem_req_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_valid", 32'(InstrValidD), 32'd0);
        check("rst_pcd", PCD, 32'd0);
        check("rst_instr", InstrD, 32'd0);

        // Phase A: streaming from reset, latency 1
        push_range(32'h100, 8);
        @(posedge clk); #1;
        rst_n = 1'b1;
        imem_req_ready = 1'b1;
        @(negedge clk);
        check("a_addr0", imem_addr, 32'h100);
        check("a_req0", 32'(imem_req_valid), 32'd1);
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (k == 8) StallF = 1'b1;
            @(negedge clk);
            if (k <= 2) check("a_addr", imem_addr, 32'h100 + 32'(4 * k));
            if (k == 2) check("a_not_yet_valid", 32'(InstrValidD), 32'd0);
            if (k == 3) check("a_first_pcd", PCD, 32'h100);
            if (k >= 3) check("a_stream_valid", 32'(InstrValidD), 32'd1);
        end
        drain();

        // Phase B: StallF+StallD for 3 edges mid-stream
        push_range(32'h120, 8);
        StallF = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            @(posedge clk); #1;
            if (k == 4) begin StallF = 1'b1; StallD = 1'b1; end
            if (k == 7) begin StallF = 1'b0; StallD = 1'b0; end
            if (k == 11) StallF = 1'b1;
            @(negedge clk);
            if (k >= 4 && k <= 6) check("b_no_req_stallf", 32'(imem_req_valid), 32'd0);
            if (k >= 5 && k <= 7) check("b_hold_pcd", PCD, 32'h124);
        end
        drain();

        // Phase C: FlushD and StallD together
        push_range(32'h140, 6);
        StallF = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk); #1;
            if (k == 4) begin StallF = 1'b1; StallD = 1'b1; FlushD = 1'b1; end
            if (k == 5) begin StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; end
            if (k == 7) StallF = 1'b1;
            @(negedge clk);
            if (k == 5) check("c_flush_bubble", 32'(InstrValidD), 32'd0);
            if (k == 6) check("c_head_kept_pcd", PCD, 32'h148);
        end
        drain();

        // Phase D: memory not ready for 4 edges
        push_range(32'h158, 5);
        StallF = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk); #1;
            if (k == 3) imem_req_ready = 1'b0;
            if (k == 7) imem_req_ready = 1'b1;
            if (k == 9) StallF = 1'b1;
            @(negedge clk);
            if (k >= 3 && k <= 6) begin
                check("d_req_held", 32'(imem_req_valid), 32'd1);
                check("d_addr_stable", imem_addr, 32'h164);
            end
            if (k == 6 || k == 7) check("d_bubble", 32'(InstrValidD), 32'd0);
        end
        drain();

        // Phase E: redirect with two responses in flight (latency 3)
        lat = 3;
        push_range(32'h200, 4);
        StallF = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk); #1;
            if (k == 2) begin BranchTakenE = 1'b1; BranchTargetE = 32'h200; end
            if (k == 3) BranchTakenE = 1'b0;
            if (k == 7) StallF = 1'b1;
            @(negedge clk);
            if (k == 2) check("e_no_req_redirect", 32'(imem_req_valid), 32'd0);
            if (k == 3) begin
                check("e_target_addr", imem_addr, 32'h200);
                check("e_target_req", 32'(imem_req_valid), 32'd1);
            end
        end
        drain();
`ifdef FETCH_PERF_EN
        check("e_perf_drop", 32'(perf_drop_cnt), 32'd2);
`endif
        lat = 1;

        // Phase F: redirect while StallF holds fetch
        push_range(32'h300, 2);
        BranchTakenE = 1'b1;
        BranchTargetE = 32'h300;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            if (k == 1) BranchTakenE = 1'b0;
            if (k == 3) StallF = 1'b0;
            if (k == 5) StallF = 1'b1;
            @(negedge clk);
            if (k <= 2) begin
                check("f_no_req_stallf", 32'(imem_req_valid), 32'd0);
                check("f_pc_loaded", imem_addr, 32'h300);
            end
            if (k == 3) begin
                check("f_req_resumes", 32'(imem_req_valid), 32'd1);
                check("f_req_addr", imem_addr, 32'h300);
            end
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
        $finish;
    end

endmodule
